// File: rtl/uart_tx_sched.sv
// uart_tx_sched: debounced two-button request latch with a round-robin
// arbiter. It issues one UART character per grant through a start/busy
// handshake and drives the constant baud divisor.
// Optional feature macro: UART_TX_SCHED_DEBOUNCE_EN (debounce counters present).
module uart_tx_sched #(
    parameter int unsigned DB_CYCLES = 36864,
    parameter logic [11:0] UBRR_VAL  = 12'd23,
    parameter logic [7:0]  CHAR_A    = 8'd65,
    parameter logic [7:0]  CHAR_B    = 8'd66
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button_A,
    input  logic        button_B,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  data_i,
    output logic [11:0] ubrr,
    output logic [1:0]  pend
);

    localparam int unsigned TO_CYCLES = 16;
    localparam int unsigned TO_W      = 4;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      sync_meta;
    logic [1:0]      sync_q;
    logic [1:0]      db_lvl;
    logic [1:0]      db_prev;
    logic [1:0]      press;
    logic            grant_a;
    logic            grant_b;
    logic [1:0]      pend_nxt;
    logic            last;
    logic            last_nxt;
    logic [7:0]      data_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;

    // Two-flop synchronisers for both raw buttons; released level is 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 2'b11;
            sync_q    <= 2'b11;
        end else begin
            sync_meta <= {button_B, button_A};
            sync_q    <= sync_meta;
        end
    end

`ifdef UART_TX_SCHED_DEBOUNCE_EN
    localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_TOP = DB_W'(DB_CYCLES - 1);

    logic [1:0][DB_W-1:0] db_cnt;

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_lvl <= 2'b11;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_TOP) begin
                        db_lvl[i] <= sync_q[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    // Debouncer bypassed: the debounced level is the synchronised level
    assign db_lvl = sync_q;
`endif

    // Previous debounced level for the falling-edge (press) detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_prev <= 2'b11;
        end else begin
            db_prev <= db_lvl;
        end
    end

    assign press = db_prev & ~db_lvl;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbitration and next values of the registered outputs
    always_comb begin
        state_nxt  = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        to_cnt_nxt = to_cnt;
        case (state)
            S_IDLE: begin
                if ((pend != 2'b00) && !tx_busy) begin
                    if (pend == 2'b01) begin
                        grant_a = 1'b1;
                    end else if (pend == 2'b10) begin
                        grant_b = 1'b1;
                    end else if (last) begin
                        grant_a = 1'b1;
                    end else begin
                        grant_b = 1'b1;
                    end
                    state_nxt = S_START;
                end
            end
            S_START: begin
                to_cnt_nxt = '0;
                state_nxt  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A new press overrides a same-cycle clear from the grant
        pend_nxt = (pend & ~{grant_b, grant_a}) | press;

        last_nxt = last;
        data_nxt = data_i;
        if (grant_a) begin
            last_nxt = 1'b0;
            data_nxt = CHAR_A;
        end else if (grant_b) begin
            last_nxt = 1'b1;
            data_nxt = CHAR_B;
        end
    end

    // Registered outputs, arbiter pointer and handshake timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_start <= 1'b0;
            data_i   <= '0;
            ubrr     <= '0;
            pend     <= '0;
            last     <= 1'b1;
            to_cnt   <= '0;
        end else begin
            tx_start <= (state_nxt == S_START);
            data_i   <= data_nxt;
            ubrr     <= UBRR_VAL;
            pend     <= pend_nxt;
            last     <= last_nxt;
            to_cnt   <= to_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (DB_CYCLES=4); a small UART model answers
// tx_start with busy, and a monitor counts starts and handshake violations.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        button_A;
    logic        button_B;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  data_i;
    logic [11:0] ubrr;
    logic [1:0]  pend;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0;
    int viol = 0;
    logic [7:0] last_char = 8'd0;
    logic prev_start = 1'b0;

    logic model_en = 1'b0;
    int   busy_len = 20;
    int   m_phase;
    int   m_cnt;

    uart_tx_sched #(
        .DB_CYCLES(4),
        .UBRR_VAL (12'd23),
        .CHAR_A   (8'd65),
        .CHAR_B   (8'd66)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button_A(button_A),
        .button_B(button_B),
        .tx_busy (tx_busy),
        .tx_start(tx_start),
        .data_i  (data_i),
        .ubrr    (ubrr),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count starts, remember the character, flag illegal starts
    always @(negedge clk) begin
        prev_start <= tx_start;
        if (tx_start) begin
            n_start   <= n_start + 1;
            last_char <= data_i;
            if (tx_busy || prev_start) viol <= viol + 1;
        end
    end

    // UART model: busy rises 2 cycles after tx_start and stays up busy_len cycles
    initial begin
        tx_busy = 1'b0;
        m_phase = 0;
        m_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!model_en) begin
                tx_busy = 1'b0;
                m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (tx_start) begin m_cnt = 2; m_phase = 1; end
                    1: begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin tx_busy = 1'b1; m_cnt = busy_len; m_phase = 2; end
                    end
                    default: begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin tx_busy = 1'b0; m_phase = 0; end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget, output int t);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!tx_start && k < budget);
        chk("start_seen", 32'(tx_start), 32'd1);
        t = cyc;
    endtask

    initial begin
        int base;
        int t0;
        int t1;
        int t2;
        logic bounce_pend;

        // Reset with buttons toggling
        rst = 1'b0;
        button_A = 1'b1;
        button_B = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            button_A = ~button_A;
            button_B = button_A;
        end
        button_A = 1'b1;
        button_B = 1'b1;
        tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(data_i), 32'd0);
        chk("rst_ubrr", 32'(ubrr), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_ubrr", 32'(ubrr), 32'd23);
        chk("rel_tx_start", 32'(tx_start), 32'd0);
        chk("rel_pend", 32'(pend), 32'd0);
        repeat (4) tick();

        // Single press of A with exact pin-to-pend and pend-to-start latency
        model_en = 1'b1;
        busy_len = 20;
        base = n_start;
        button_A = 1'b0;
        repeat (LAT) tick();
        chk("single_pend", 32'(pend), 32'd1);
        tick();
        chk("single_start", 32'(tx_start), 32'd1);
        chk("single_data", 32'(data_i), 32'd65);
        chk("single_pend_clr", 32'(pend), 32'd0);
        repeat (10 - LAT - 1) tick();
        button_A = 1'b1;
        repeat (40) tick();
        chk("single_count", 32'(n_start - base), 32'd1);
        chk("single_char", 32'(last_char), 32'd65);
        chk("single_pend_end", 32'(pend), 32'd0);

        // Button B: bounce first (debounce build), then a clean hold
        base = n_start;
        bounce_pend = 1'b0;
`ifdef UART_TX_SCHED_DEBOUNCE_EN
        for (int i = 0; i < 5; i++) begin
            button_B = 1'b0;
            tick(); bounce_pend |= pend[1];
            tick(); bounce_pend |= pend[1];
            button_B = 1'b1;
            tick(); bounce_pend |= pend[1];
            tick(); bounce_pend |= pend[1];
        end
`endif
        chk("bounce_no_pend", 32'(bounce_pend), 32'd0);
        button_B = 1'b0;
        wait_start(40, t0);
        chk("bounce_data", 32'(data_i), 32'd66);
        repeat (40) tick();
        chk("bounce_count", 32'(n_start - base), 32'd1);
        button_B = 1'b1;
        repeat (12) tick();

        // Reset pulse, then simultaneous press: A first, B second tie
        rst = 1'b0;
        tick();
        chk("rst2_pend", 32'(pend), 32'd0);
        chk("rst2_ubrr", 32'(ubrr), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst2_ubrr_rel", 32'(ubrr), 32'd23);
        button_A = 1'b0;
        button_B = 1'b0;
        repeat (LAT) tick();
        chk("tie_pend", 32'(pend), 32'd3);
        tick();
        chk("tie_start", 32'(tx_start), 32'd1);
        chk("tie_first_data", 32'(data_i), 32'd65);
        chk("tie_pend_b", 32'(pend), 32'd2);
        t0 = cyc;
        button_A = 1'b1;
        repeat (8) tick();
        button_A = 1'b0;
        repeat (11) tick();
        chk("tie2_pend", 32'(pend), 32'd3);
        wait_start(20, t1);
        chk("tie2_first_data", 32'(data_i), 32'd66);
        chk("tie_gap_b", 32'(t1 - t0), 32'd24);
        button_B = 1'b1;
        wait_start(40, t2);
        chk("tie2_second_data", 32'(data_i), 32'd65);
        chk("tie_gap_a", 32'(t2 - t1), 32'd24);
        button_A = 1'b1;
        repeat (40) tick();

        // Two presses of A during its own frame: one extra frame only
        busy_len = 40;
        base = n_start;
        button_A = 1'b0;
        wait_start(20, t0);
        chk("busy_first_data", 32'(data_i), 32'd65);
        button_A = 1'b1;
        repeat (6) tick();
        button_A = 1'b0;
        repeat (6) tick();
        button_A = 1'b1;
        repeat (6) tick();
        button_A = 0;
        repeat (12) tick();
        chk("busy_pend", 32'(pend), 32'd1);
        wait_start(40, t1);
        chk("busy_extra_data", 32'(data_i), 32'd65);
        chk("busy_gap", 32'(t1 - t0), 32'd44);
        button_A = 1'b1;
        repeat (60) tick();
        chk("busy_count", 32'(n_start - base), 32'd2);
        chk("busy_pend_end", 32'(pend), 32'd0);

        // Timeout: busy never rises; a pending A is served right after timeout
        model_en = 1'b0;
        busy_len = 20;
        repeat (4) tick();
        base = n_start;
        button_B = 1'b0;
        wait_start(20, t0);
        chk("to_data_b", 32'(data_i), 32'd66);
        button_A = 1'b0;
        repeat (10) tick();
        chk("to_pend_a", 32'(pend), 32'd1);
        wait_start(30, t1);
        chk("to_gap", 32'(t1 - t0), 32'd18);
        chk("to_data_a", 32'(data_i), 32'd65);
        button_A = 1'b1;
        button_B = 1'b1;
        repeat (40) tick();
        chk("to_count", 32'(n_start - base), 32'd2);
        chk("to_pend_end", 32'(pend), 32'd0);

        chk("start_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler sitting between the two front-panel buttons and the UART transmitter. It synchronises and debounces both buttons and latches one pending request per button. It arbitrates round-robin between the two requesters and issues one character per grant to the UART TX with a start/busy handshake. It also drives the constant baud divisor `ubrr` into the UART. All logic runs on the 3.6864 MHz system clock.

## Interface
- `DB_CYCLES`, default 36864: consecutive stable cycles required to accept a new button level (10 ms).
- `UBRR_VAL`, default 12'd23: baud divisor for 9600 baud.
- `CHAR_A`, default 8'd65: character sent for button A ('A').
- `CHAR_B`, default 8'd66: character sent for button B ('B').
- `clk`  in  1  system clock, 3.6864 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `button_A`  in  1  raw button, active low, asynchronous.
- `button_B`  in  1  raw button, active low, asynchronous.
- `tx_busy`  in  1  UART TX busy; high while a frame is shifting out.
- `tx_start`  out  1  one-cycle start pulse to UART TX.
- `data_i`  out  8  character to transmit; valid when `tx_start` is high and held until the next grant.
- `ubrr`  out  12  baud divisor to the UART.
- `pend`  out  2  pending request flags: [0]=A, [1]=B.

## Operation
- Input path per button: 2-FF synchroniser, then debouncer, then a falling-edge detector on the debounced level. A press is a 1→0 transition.
- Debouncer: a counter increments while the synchronised level differs from the debounced level and clears when they match. When the count reaches DB_CYCLES-1, the debounced level takes the synchronised level and the counter clears. The counter must be wide enough for DB_CYCLES; no wrap.
- A press sets `pend[x]`. A press while `pend[x]` is already 1 is dropped (single entry per requester). If a set and a clear hit `pend[x]` in the same cycle, the set wins.
- Round-robin pointer `last` (0=A, 1=B) holds the most recent grant; its reset value is 1, so A wins the first tie.
- FSM states:
  - IDLE: if `pend`≠0 and `tx_busy`=0, grant A if only A is pending, B if only B is pending, and on a tie grant the requester other than `last`. On a grant: load `data_i` with CHAR_x, clear `pend[x]`, update `last`, go to START.
  - START: `tx_start`=1 for this cycle only; go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO. If `tx_busy` stays low for 16 cycles, time out and return to IDLE; the grant is consumed and not retried.
  - WAIT_LO: wait for `tx_busy`=0, then go to IDLE.
- `ubrr` is 0 in reset and UBRR_VAL on every cycle after reset release.
- Reset values: `tx_start`=0, `data_i`=0, `ubrr`=0, `pend`=0, state IDLE, `last`=1. Debounced levels reset to 1 (released) and debounce counters to 0. Synchronisers reset to 1.
- Reset asserted mid-frame: everything returns to reset values immediately. Pending and in-flight requests are lost. No `tx_start` is issued until a new press is seen.

## Timing
- All outputs are registered.
- Pin to `pend` latency with DEBOUNCE_EN: 2 sync cycles + DB_CYCLES + 1 edge cycle.
- `pend[x]`=1 in IDLE with `tx_busy`=0 in cycle k: `tx_start`=1 and the new `data_i` appear in cycle k+1, and `pend[x]`=0 in cycle k+1.
- Back-to-back: from IDLE the next grant is earliest 1 cycle after `tx_busy` falls, so the next `tx_start` is 2 cycles after the falling edge.
- `tx_start` never asserts while `tx_busy`=1, and never in two consecutive cycles.

## Configuration
- `UART_TX_SCHED_DEBOUNCE_EN` defined: the debouncer is present as described above.
- Not defined: the debounced level equals the synchronised level. Pin to `pend` latency becomes 3 cycles, DB_CYCLES is unused, and no counters are synthesised.

## Test plan
- Reset: hold `rst`=0 with buttons toggling → all outputs 0. One cycle after release `ubrr`=23, with `tx_start` and `pend` still 0.
- Single press (DB_CYCLES=4): button_A low for 10 cycles, `tx_busy` raised 2 cycles after `tx_start` for 20 cycles → exactly one `tx_start` with `data_i`=65, and `pend`=00 afterwards.
- Bounce (debounce enabled, DB_CYCLES=4): button_B toggles every 2 cycles for 20 cycles, then is held low → no `pend` during the toggling, then exactly one grant with `data_i`=66.
- Simultaneous press: both buttons pressed in the same cycle after reset → grant A (65) first. B (66) follows 2 cycles after `tx_busy` falls. A second tie → B is granted first.
- Press during busy: A pressed twice while its frame is in WAIT_LO → `pend[0]` is set once and exactly one extra A frame is sent after `tx_busy` falls.
- Timeout: `tx_busy` held 0 after `tx_start` → FSM returns to IDLE after 16 cycles, `pend`=00, and no repeat `tx_start`.
